npu_instr_dispatcher: RTL and testbench

NPU_INSTR_DISPATCHER -- requirements
Module: npu_instr_dispatcher

---
 rtl/npu_instr_dispatcher_pkg.sv | 30 +++
 rtl/npu_instr_dispatcher_fifo.sv | 62 ++++++
 rtl/npu_instr_dispatcher.sv | 145 ++++++++++++++
 tb/tb_npu_instr_dispatcher.sv | 368 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/npu_instr_dispatcher_pkg.sv
// rtl/npu_instr_dispatcher_pkg.sv - shared widths, opcode field, MVM opcode and FSM encodings
`ifndef NPU_INSTR_DISPATCHER_DEFINES
`define NPU_INSTR_DISPATCHER_DEFINES
`define INSTR_WIDTH 32
`define DRAM_AWIDTH 16
`define DRAM_DWIDTH 32
`endif

package npu_instr_dispatcher_pkg;

   localparam int INSTR_WIDTH  = `INSTR_WIDTH;
   localparam int DRAM_AWIDTH  = `DRAM_AWIDTH;
   localparam int DRAM_DWIDTH  = `DRAM_DWIDTH;

   // Opcode lives in the top nibble of every instruction word
   localparam int OPCODE_MSB   = INSTR_WIDTH - 1;
   localparam int OPCODE_WIDTH = 4;
   localparam logic [OPCODE_WIDTH-1:0] OPCODE_MVM = 4'hF;

   // Dispatcher FSM encodings
   localparam logic [1:0] ST_RST_HOLD = 2'd0;
   localparam logic [1:0] ST_IDLE     = 2'd1;
   localparam logic [1:0] ST_ISSUE    = 2'd2;
   localparam logic [1:0] ST_WAIT_MVM = 2'd3;

   function automatic logic is_mvm(input logic [INSTR_WIDTH-1:0] word);
      return word[OPCODE_MSB -: OPCODE_WIDTH] == OPCODE_MVM;
   endfunction

endpackage

// File: rtl/npu_instr_dispatcher_fifo.sv
// rtl/npu_instr_dispatcher_fifo.sv - npu_instr_fifo: instruction queue, power-of-two depth, count-based full/empty
import npu_instr_dispatcher_pkg::*;

module npu_instr_fifo #(
   parameter int DEPTH = 8,
   parameter int WIDTH = INSTR_WIDTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic             full,
   output logic             empty
);

   localparam int PW = $clog2(DEPTH);
   localparam logic [PW:0] FULL_COUNT = (PW+1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic [PW:0]      count;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == FULL_COUNT);
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign head    = mem[rd_ptr];

   // Storage array: written only on an accepted push, never reset
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= push_data;
      end
   end

   // Pointers wrap naturally at DEPTH; count alone decides full/empty
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + PW'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + PW'(1);
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + (PW+1)'(1);
            2'b01:   count <= count - (PW+1)'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/npu_instr_dispatcher.sv
// rtl/npu_instr_dispatcher.sv - host queue, dispatch FSM and NPU DRAM store; NPU_DISPATCH_TIMEOUT_EN adds an MVM watchdog
import npu_instr_dispatcher_pkg::*;

module npu_instr_dispatcher #(
   parameter int FIFO_DEPTH = 8,
   parameter int DRAM_WORDS = 256,
   parameter int RST_HOLD   = 2
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   host_instr_valid,
   input  logic [INSTR_WIDTH-1:0] host_instr,
   output logic                   host_instr_ready,
   output logic [INSTR_WIDTH-1:0] instruction,
   output logic                   reset_npu,
   input  logic                   done_mvm,
   input  logic [DRAM_AWIDTH-1:0] dram_addr,
   input  logic                   dram_write_enable,
   input  logic [DRAM_DWIDTH-1:0] output_data_DRAM,
   output logic [DRAM_DWIDTH-1:0] input_data_DRAM,
   output logic                   idle,
   output logic                   timeout_err
);

   localparam int MEM_AW = $clog2(DRAM_WORDS);
   localparam logic [7:0] HOLD_LAST = 8'(RST_HOLD - 1);

   logic [1:0]             state;
   logic [7:0]             hold_cnt;
   logic [INSTR_WIDTH-1:0] instr_q;
   logic [INSTR_WIDTH-1:0] fifo_head;
   logic                   fifo_full;
   logic                   fifo_empty;
   logic                   push;
   logic                   pop;
   logic                   mvm_timeout;
   logic [DRAM_DWIDTH-1:0] mem [DRAM_WORDS];
   logic [MEM_AW-1:0]      mem_addr;
   logic [DRAM_AWIDTH-1:0] unused_dram_addr;

   // Ready depends only on registered state, never on host_instr_valid
   assign host_instr_ready = !fifo_full && (state != ST_RST_HOLD);
   assign push             = host_instr_valid && host_instr_ready;
   assign pop              = (state == ST_IDLE) && !fifo_empty;
   assign instruction      = (state == ST_ISSUE) ? instr_q : '0;
   assign reset_npu        = (state == ST_RST_HOLD);
   assign idle             = (state == ST_IDLE) && fifo_empty;

   npu_instr_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (INSTR_WIDTH)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (push),
      .push_data (host_instr),
      .pop       (pop),
      .head      (fifo_head),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   // Dispatch FSM: hold NPU in reset, then pop/issue one word at a time, stalling on MVM
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= ST_RST_HOLD;
         hold_cnt <= '0;
         instr_q  <= '0;
      end else begin
         case (state)
            ST_RST_HOLD: begin
               if (hold_cnt == HOLD_LAST) begin
                  state <= ST_IDLE;
               end else begin
                  hold_cnt <= hold_cnt + 8'd1;
               end
            end
            ST_IDLE: begin
               if (pop) begin
                  instr_q <= fifo_head;
                  state   <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               state <= is_mvm(instr_q) ? ST_WAIT_MVM : ST_IDLE;
            end
            ST_WAIT_MVM: begin
               if (done_mvm || mvm_timeout) begin
                  state <= ST_IDLE;
               end
            end
            default: state <= ST_RST_HOLD;
         endcase
      end
   end

`ifdef NPU_DISPATCH_TIMEOUT_EN
   logic [15:0] wait_cnt;
   logic        timeout_q;

   assign mvm_timeout = (state == ST_WAIT_MVM) && !done_mvm && (wait_cnt == 16'hFFFF);
   assign timeout_err = timeout_q;

   // Watchdog: counts cycles spent in WAIT_MVM; the error flag stays set until reset
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wait_cnt  <= '0;
         timeout_q <= 1'b0;
      end else begin
         if (state == ST_WAIT_MVM) begin
            wait_cnt <= wait_cnt + 16'd1;
         end else begin
            wait_cnt <= '0;
         end
         if (mvm_timeout) begin
            timeout_q <= 1'b1;
         end
      end
   end
`else
   assign mvm_timeout = 1'b0;
   assign timeout_err = 1'b0;
`endif

   // Address bits above the store depth are ignored (address taken modulo DRAM_WORDS)
   assign unused_dram_addr = dram_addr;
   assign mem_addr         = dram_addr[MEM_AW-1:0];

   // DRAM write port; contents survive reset
   always_ff @(posedge clk) begin
      if (dram_write_enable) begin
         mem[mem_addr] <= output_data_DRAM;
      end
   end

   // Registered read every cycle; a same-cycle write is not forwarded, so old data is returned
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         input_data_DRAM <= '0;
      end else begin
         input_data_DRAM <= mem[mem_addr];
      end
   end

endmodule

// File: tb/tb_npu_instr_dispatcher.sv
// tb/tb_npu_instr_dispatcher.sv - randomized self-checking bench for npu_instr_dispatcher
module tb_npu_instr_dispatcher;
   import npu_instr_dispatcher_pkg::*;

   localparam int HOLD = 2;

   logic                   clk;
   logic                   reset;
   logic                   host_instr_valid;
   logic [INSTR_WIDTH-1:0] host_instr;
   logic                   host_instr_ready;
   logic [INSTR_WIDTH-1:0] instruction;
   logic                   reset_npu;
   logic                   done_mvm;
   logic [DRAM_AWIDTH-1:0] dram_addr;
   logic                   dram_write_enable;
   logic [DRAM_DWIDTH-1:0] output_data_DRAM;
   logic [DRAM_DWIDTH-1:0] input_data_DRAM;
   logic                   idle;
   logic                   timeout_err;

   int n_checks   = 0;
   int n_errors   = 0;
   int n_issued   = 0;
   int n_accepted = 0;

   logic [INSTR_WIDTH-1:0] exp_q [$];
   logic [INSTR_WIDTH-1:0] prev_instr;
   logic [INSTR_WIDTH-1:0] exp_word;
   bit                     mvm_pending;
   bit                     timeout_seen;
   bit                     stop_done;
   logic [DRAM_DWIDTH-1:0] model_mem [256];
   bit                     model_vld [256];

   npu_instr_dispatcher #(
      .FIFO_DEPTH (8),
      .DRAM_WORDS (256),
      .RST_HOLD   (HOLD)
   ) dut (
      .clk               (clk),
      .reset             (reset),
      .host_instr_valid  (host_instr_valid),
      .host_instr        (host_instr),
      .host_instr_ready  (host_instr_ready),
      .instruction       (instruction),
      .reset_npu         (reset_npu),
      .done_mvm          (done_mvm),
      .dram_addr         (dram_addr),
      .dram_write_enable (dram_write_enable),
      .output_data_DRAM  (output_data_DRAM),
      .input_data_DRAM   (input_data_DRAM),
      .idle              (idle),
      .timeout_err       (timeout_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [INSTR_WIDTH-1:0] rand_word(input bit mvm);
      logic [INSTR_WIDTH-1:0] w;
      w = $urandom;
      w[INSTR_WIDTH-1 -: 4] = mvm ? 4'hF : 4'($urandom_range(0, 14));
      w[0] = 1'b1;
      return w;
   endfunction

   // Reference model of the dispatch rules: issue order, one-cycle pulses, MVM gating
   always @(negedge clk) begin
      if (reset) begin
         mvm_pending  = 1'b0;
         timeout_seen = 1'b0;
         prev_instr   = '0;
      end else begin
         if (timeout_err && !timeout_seen) begin
            timeout_seen = 1'b1;
            mvm_pending  = 1'b0;
         end
         if (instruction != '0) begin
            n_issued++;
            check("nop_between", prev_instr, 0);
            check("issue_gated", mvm_pending, 0);
            if (exp_q.size() == 0) begin
               check("unexpected_issue", instruction, 0);
            end else begin
               exp_word = exp_q.pop_front();
               check("issue_order", instruction, exp_word);
            end
            if (instruction[INSTR_WIDTH-1 -: 4] == 4'hF) mvm_pending = 1'b1;
         end else if (done_mvm && mvm_pending) begin
            mvm_pending = 1'b0;
         end
         prev_instr = instruction;
      end
   end

   task automatic push_word(input logic [INSTR_WIDTH-1:0] w);
      int budget = 0;
      bit ok = 1'b0;
      host_instr_valid = 1'b1;
      host_instr       = w;
      while (!ok && budget < 2000) begin
         @(negedge clk);
         ok = host_instr_ready;
         @(posedge clk);
         #1;
         budget++;
      end
      host_instr_valid = 1'b0;
      if (ok) begin
         exp_q.push_back(w);
         n_accepted++;
      end else begin
         check("push_timeout", 0, 1);
      end
   endtask

   task automatic wait_issues(input int target, input int budget);
      int n = 0;
      while (n_issued < target && n < budget) begin
         @(negedge clk);
         #1;
         n++;
      end
      check("wait_issue", n_issued >= target, 1);
      @(posedge clk);
      #1;
   endtask

   task automatic wait_drain(input int budget);
      int n = 0;
      while (exp_q.size() != 0 && n < budget) begin
         @(negedge clk);
         #1;
         n++;
      end
      check("drain", exp_q.size(), 0);
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      int hold = 0;
      reset = 1'b1;
      exp_q.delete();
      #1;
      check("rst_reset_npu", reset_npu, 1);
      check("rst_ready", host_instr_ready, 0);
      check("rst_idle", idle, 0);
      check("rst_instruction", instruction, 0);
      check("rst_timeout", timeout_err, 0);
      check("rst_dram_rd", input_data_DRAM, 0);
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (reset_npu) hold++;
         else break;
      end
      check("hold_cycles", hold, HOLD);
      check("idle_after_hold", idle, 1);
      check("ready_after_hold", host_instr_ready, 1);
      @(posedge clk);
      #1;
   endtask

   task automatic dram_step(input logic [DRAM_AWIDTH-1:0] a, input logic we, input logic [DRAM_DWIDTH-1:0] d);
      int idx;
      logic [DRAM_DWIDTH-1:0] exp_rd;
      bit vld;
      idx    = int'(a % 16'd256);
      exp_rd = model_mem[idx];
      vld    = model_vld[idx];
      dram_addr         = a;
      dram_write_enable = we;
      output_data_DRAM  = d;
      if (we) begin
         model_mem[idx] = d;
         model_vld[idx] = 1'b1;
      end
      @(posedge clk);
      @(negedge clk);
      if (vld) check("dram_rd", input_data_DRAM, exp_rd);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL global_timeout got 1 expected 0");
      $fatal(1, "simulation time limit");
   end

   initial begin
      int base;
      int acc0;
      int cnt;
      reset             = 1'b0;
      host_instr_valid  = 1'b0;
      host_instr        = '0;
      done_mvm          = 1'b0;
      dram_addr         = '0;
      dram_write_enable = 1'b0;
      output_data_DRAM  = '0;
      stop_done         = 1'b0;
      #3;
      do_reset();

      // three non-MVM words back to back
      base = n_issued;
      push_word(rand_word(0));
      push_word(rand_word(0));
      push_word(rand_word(0));
      wait_drain(50);
      check("abc_issued", n_issued - base, 3);

      // done_mvm while idle is ignored; MVM stalls the next word until done_mvm
      done_mvm = 1'b1;
      tick();
      done_mvm = 1'b0;
      tick();
      @(negedge clk);
      check("idle_done_ignored", idle, 1);
      @(posedge clk);
      #1;
      base = n_issued;
      push_word(rand_word(1));
      push_word(rand_word(0));
      wait_issues(base + 1, 20);
      repeat (10) tick();
      @(negedge clk);
      #1;
      check("mvm_hold", n_issued - base, 1);
      @(posedge clk);
      #1;
      done_mvm = 1'b1;
      tick();
      done_mvm = 1'b0;
      wait_issues(base + 2, 20);
      check("d_after_done", n_issued - base, 2);

      // fill the queue behind a stalled MVM
      base = n_issued;
      push_word(rand_word(1));
      wait_issues(base + 1, 20);
      acc0 = n_accepted;
      fork
         begin
            for (int i = 0; i < 9; i++) push_word(rand_word(0));
         end
      join_none
      repeat (15) tick();
      @(negedge clk);
      check("fill_accepted", n_accepted - acc0, 8);
      check("full_ready_low", host_instr_ready, 0);
      check("fill_queue", exp_q.size(), 8);
      @(posedge clk);
      #1;
      done_mvm = 1'b1;
      tick();
      done_mvm = 1'b0;
      wait fork;
      wait_drain(200);
      check("fill_issued", n_issued - base, 10);

      // DRAM directed then random, including aliased addresses and same-cycle read/write
      dram_step(16'd3, 1'b1, 32'hA5);
      dram_step(16'd3, 1'b0, 32'h0);
      check("dram_a5", input_data_DRAM, 32'hA5);
      dram_step(16'h0103, 1'b1, 32'h5A);
      check("dram_raw_old", input_data_DRAM, 32'hA5);
      dram_step(16'd3, 1'b0, 32'h0);
      check("dram_new", input_data_DRAM, 32'h5A);
      for (int i = 0; i < 60; i++) begin
         dram_step(DRAM_AWIDTH'(($urandom & 32'hFF00) | $urandom_range(0, 7)),
                   1'($urandom_range(0, 1)), $urandom);
      end
      dram_write_enable = 1'b0;
      tick();

      // random dispatch traffic with random done_mvm pulses
      base = n_issued;
      fork
         begin
            while (!stop_done) begin
               done_mvm = ($urandom_range(0, 4) == 0);
               tick();
            end
            done_mvm = 1'b0;
         end
      join_none
      for (int i = 0; i < 60; i++) begin
         repeat ($urandom_range(0, 3)) tick();
         push_word(rand_word($urandom_range(0, 3) == 0));
      end
      wait_drain(2000);
      check("rand_issued", n_issued - base, 60);
      stop_done = 1'b1;
      tick();
      tick();
      done_mvm = 1'b1;
      tick();
      done_mvm = 1'b0;
      tick();
      @(negedge clk);
      check("idle_after_rand", idle, 1);
      @(posedge clk);
      #1;

      // reset while an MVM wait is in flight and a word is queued
      base = n_issued;
      push_word(rand_word(1));
      push_word(rand_word(0));
      wait_issues(base + 1, 20);
      repeat (3) tick();
      do_reset();
      base = n_issued;
      repeat (10) tick();
      @(negedge clk);
      check("post_reset_no_issue", n_issued - base, 0);
      check("post_reset_idle", idle, 1);
      @(posedge clk);
      #1;

`ifdef NPU_DISPATCH_TIMEOUT_EN
      base = n_issued;
      push_word(rand_word(1));
      push_word(rand_word(0));
      wait_issues(base + 1, 20);
      cnt = 0;
      while (!timeout_err && cnt < 70000) begin
         @(negedge clk);
         cnt++;
      end
      check("timeout_set", timeout_err, 1);
      check("timeout_window", (cnt >= 65535) && (cnt <= 65537), 1);
      @(posedge clk);
      #1;
      wait_issues(base + 2, 20);
      check("timeout_sticky", timeout_err, 1);
      base = n_issued;
      push_word(rand_word(1));
      wait_issues(base + 1, 20);
      repeat (100) tick();
      do_reset();
      check("timeout_cleared", timeout_err, 0);
`else
      cnt = 0;
      check("timeout_tied", timeout_err, 0);
`endif

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
